// File: rtl/adder_arb_pkg.sv
// ============================================================================
// adder_arb_pkg : shared types and helpers for the shared adder arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package adder_arb_pkg;

   localparam int WIDTH = 20;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      DONE   = 2'd2
   } state_t;

   // Width needed to hold values 0..v-1, never less than one bit
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational round-robin arbiter, search starts after i_last
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_last,
   output logic [N-1:0]  o_grant,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   always_comb begin
      int          j;
      logic [IW-1:0] w_j;
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      j       = 0;
      w_j     = '0;
      // Walk from farthest to nearest so the nearest requester after i_last wins
      for (int k = N; k >= 1; k--) begin
         j = int'(i_last) + k;
         if (j >= N) j = j - N;
         w_j = IW'(j);
         if (i_req[w_j]) begin
            o_grant      = '0;
            o_grant[w_j] = 1'b1;
            o_idx        = w_j;
            o_any        = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/twentyBitAdder.sv
// ============================================================================
// twentyBitAdder : 20-bit ripple-carry adder built from full-adder cells
// Rev 1.0
// ============================================================================
`default_nettype none

module twentyBitAdder (
   input  logic [19:0] i_a,
   input  logic [19:0] i_b,
   input  logic        i_cin,
   output logic [19:0] o_sum,
   output logic        o_cout
);

   logic [20:0] w_c;

   assign w_c[0] = i_cin;

   for (genvar i = 0; i < 20; i++) begin : g_bit
      assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
      assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
   end

   assign o_cout = w_c[20];

endmodule

`default_nettype wire

// File: rtl/shared_adder_arbiter.sv
// ============================================================================
// shared_adder_arbiter : round-robin time-sharing of one 20-bit ripple adder
// Rev 1.0
// ============================================================================
`default_nettype none

module shared_adder_arbiter
   import adder_arb_pkg::*;
#(
   parameter int NREQ          = 4,
   parameter int WIDTH         = adder_arb_pkg::WIDTH,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       i_req_valid,
   input  logic [NREQ*WIDTH-1:0] i_req_a,
   input  logic [NREQ*WIDTH-1:0] i_req_b,
   output logic [NREQ-1:0]       o_req_ready,
   output logic [NREQ-1:0]       o_rsp_valid,
   output logic [WIDTH-1:0]      o_rsp_sum,
   output logic                  o_busy
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = clog2(SETTLE_CYCLES);

   if (WIDTH != adder_arb_pkg::WIDTH) begin : g_bad_width
      $error("shared_adder_arbiter: WIDTH must equal the adder width (20)");
   end
   if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("shared_adder_arbiter: SETTLE_CYCLES must be at least 1");
   end
   if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
      $error("shared_adder_arbiter: NREQ must be in 2..8");
   end

   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_op_a, r_op_b, r_rsp_sum;
   logic [IW-1:0]    r_gid, r_last;
   logic [CW-1:0]    r_cnt;

   logic [NREQ-1:0]  w_grant;
   logic [IW-1:0]    w_gidx;
   logic             w_any;
   logic [WIDTH-1:0] w_sum;
   logic             w_unused_cout;

   rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
      .i_req   (i_req_valid),
      .i_last  (r_last),
      .o_grant (w_grant),
      .o_idx   (w_gidx),
      .o_any   (w_any)
   );

   twentyBitAdder u_add (
      .i_a    (r_op_a),
      .i_b    (r_op_b),
      .i_cin  (1'b0),
      .o_sum  (w_sum),
      .o_cout (w_unused_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      o_req_ready = '0;
      o_rsp_valid = '0;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               o_req_ready = rst_n ? w_grant : '0;
               w_next      = SETTLE;
            end
         end
         SETTLE: begin
            if (r_cnt == '0) w_next = DONE;
         end
         DONE: begin
            o_rsp_valid = NREQ'(1) << r_gid;
            w_next      = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Operands are latched at accept so the adder sees stable inputs for the whole settle window
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op_a    <= '0;
         r_op_b    <= '0;
         r_gid     <= '0;
         r_cnt     <= '0;
         r_rsp_sum <= '0;
         r_last    <= IW'(NREQ - 1);
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_op_a <= i_req_a[w_gidx*WIDTH +: WIDTH];
                  r_op_b <= i_req_b[w_gidx*WIDTH +: WIDTH];
                  r_gid  <= w_gidx;
                  r_cnt  <= CW'(SETTLE_CYCLES - 1);
               end
            end
            SETTLE: begin
               if (r_cnt != '0) r_cnt     <= r_cnt - 1'b1;
               else             r_rsp_sum <= w_sum;
            end
            DONE:    r_last <= r_gid;
            default: ;
         endcase
      end
   end

   assign o_rsp_sum = r_rsp_sum;
   assign o_busy    = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_shared_adder_arbiter.sv
// ============================================================================
// tb_shared_adder_arbiter : directed self-checking bench for shared_adder_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_shared_adder_arbiter;

   localparam int NREQ = 4;
   localparam int W    = 20;

   logic              clk;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*W-1:0] req_a, req_b;
   logic [NREQ-1:0]   req_ready, rsp_valid;
   logic [W-1:0]      rsp_sum;
   logic              busy;

   int n_checks = 0;
   int n_errors = 0;

   shared_adder_arbiter #(.NREQ(NREQ), .WIDTH(W), .SETTLE_CYCLES(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_req_valid (req_valid),
      .i_req_a     (req_a),
      .i_req_b     (req_b),
      .o_req_ready (req_ready),
      .o_rsp_valid (rsp_valid),
      .o_rsp_sum   (rsp_sum),
      .o_busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
   endtask

   // Called at a falling edge while IDLE; returns at the falling edge after DONE
   task automatic single_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] exp, input string tag);
      set_ops(i, a, b);
      req_valid = NREQ'(1) << i;
      #1 chk({tag, " ready"}, 32'(req_ready), 32'(1) << i);
      @(negedge clk);
      req_valid = '0;
      chk({tag, " busy"}, 32'(busy), 32'd1);
      chk({tag, " no early rsp1"}, 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk({tag, " no early rsp2"}, 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(1) << i);
      chk({tag, " sum"}, 32'(rsp_sum), 32'(exp));
      @(negedge clk);
      chk({tag, " rsp pulse end"}, 32'(rsp_valid), 32'd0);
      chk({tag, " idle"}, 32'(busy), 32'd0);
   endtask

   logic [1:0]   rr_order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
   logic [W-1:0] rr_sum   [4] = '{20'h01011, 20'h02022, 20'h03033, 20'h04044};

   initial begin
      rst_n     = 1'b0;
      req_valid = '1;
      req_a     = '0;
      req_b     = '0;

      // Reset with every requester asserting
      @(negedge clk);
      chk("reset ready", 32'(req_ready), 32'd0);
      chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset sum", 32'(rsp_sum), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      @(negedge clk);
      req_valid = '0;
      rst_n     = 1'b1;
      @(negedge clk);

      single_op(2, 20'h00005, 20'h00007, 20'h0000C, "single");
      single_op(1, 20'hFFFFF, 20'h00001, 20'h00000, "wrap ffff+1");
      single_op(2, 20'h80000, 20'h80000, 20'h00000, "wrap 8+8");
      single_op(3, 20'h7FFFF, 20'h7FFFF, 20'hFFFFE, "wrap 7fff");

      // Round-robin with all four continuously requesting; last grant is 3
      for (int i = 0; i < NREQ; i++) set_ops(i, W'(20'h01000 * (i + 1)), W'(20'h00011 * (i + 1)));
      req_valid = '1;
      for (int n = 0; n < 5; n++) begin
         #1 chk("rr ready", 32'(req_ready), 32'(1) << rr_order[n]);
         @(negedge clk);
         chk("rr no ready while busy", 32'(req_ready), 32'd0);
         @(negedge clk);
         @(negedge clk);
         chk("rr rsp id", 32'(rsp_valid), 32'(1) << rr_order[n]);
         chk("rr sum", 32'(rsp_sum), 32'(rr_sum[rr_order[n]]));
         @(negedge clk);
      end
      req_valid = '0;

      // Operand change after accept, plus withdrawal of req 1 before grant
      set_ops(0, 20'h00100, 20'h00023);
      req_valid = 4'b0001;
      #1 chk("hold ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_a[0 +: W] = 20'hABCDE;
      set_ops(1, 20'h00001, 20'h00001);
      set_ops(2, 20'h12345, 20'h11111);
      req_valid = 4'b0110;
      @(negedge clk);
      req_valid = 4'b0100;
      @(negedge clk);
      chk("hold rsp id", 32'(rsp_valid), 32'd1);
      chk("hold latched sum", 32'(rsp_sum), 32'h00123);
      @(negedge clk);
      #1 chk("withdraw skips to 2", 32'(req_ready), 32'h4);
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      chk("withdraw rsp id", 32'(rsp_valid), 32'h4);
      chk("withdraw sum", 32'(rsp_sum), 32'h23456);
      @(negedge clk);
      chk("withdraw no rsp1", 32'(rsp_valid), 32'd0);

      // Reset during SETTLE abandons the operation
      set_ops(3, 20'h11111, 20'h22222);
      req_valid = 4'b1000;
      #1 chk("midreset ready", 32'(req_ready), 32'h8);
      @(negedge clk);
      chk("midreset settling", 32'(busy), 32'd1);
      rst_n     = 1'b0;
      req_valid = '1;
      #1;
      chk("midreset busy", 32'(busy), 32'd0);
      chk("midreset ready", 32'(req_ready), 32'd0);
      chk("midreset sum", 32'(rsp_sum), 32'd0);
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         chk("midreset no rsp", 32'(rsp_valid), 32'd0);
      end
      rst_n = 1'b1;
      #1 chk("post reset grant 0", 32'(req_ready), 32'd1);
      single_op(0, 20'h0000F, 20'h00001, 20'h00010, "post reset op");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
